// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the HD44780 line writer and its byte sequencer.
// Byte-sequencer state encodings are plain localparams so older tools can consume them.
package lcd_pkg;

   localparam int unsigned CHAR_W = 7;

   localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;
   localparam logic [7:0] LCD_SPACE         = 8'h20;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StSetup = 3'd1;
   localparam logic [2:0] StEhigh = 3'd2;
   localparam logic [2:0] StHold  = 3'd3;
   localparam logic [2:0] StWait  = 3'd4;

   // Set-DDRAM-address command for a row/column pair; column is not range-checked.
   function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
      return LCD_CMD_SET_DDRAM | (row ? LCD_ROW1_BASE : 8'h00) | {4'h0, col};
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one byte onto the LCD bus: setup, E pulse, hold and settle wait.
// A new go is taken either when idle or in the last wait cycle, so bytes stream back-to-back.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned E_HIGH_CYC = 12,
   parameter int unsigned WAIT_CYC   = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go_i,
   input  logic       rs_i,
   input  logic [7:0] byte_i,
   output logic       ack_o,
   output logic       lcd_rs_o,
   output logic       lcd_e_o,
   output logic [7:0] lcd_data_o
);

   localparam int unsigned MaxAB  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
   localparam int unsigned MaxCyc = (MaxAB > WAIT_CYC) ? MaxAB : WAIT_CYC;
   localparam int unsigned TimerW = $clog2(MaxCyc + 1);

   logic [2:0]        state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              rs_q, rs_d;
   logic              e_q, e_d;
   logic [7:0]        data_q, data_d;

   logic setup_end, ehigh_end, wait_end, take_go;

   assign setup_end = (timer_q == TimerW'(SETUP_CYC - 1));
   assign ehigh_end = (timer_q == TimerW'(E_HIGH_CYC - 1));
   assign wait_end  = (timer_q == TimerW'(WAIT_CYC - 1));

   assign ack_o   = (state_q == StWait) && wait_end;
   assign take_go = go_i && ((state_q == StIdle) || ack_o);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      rs_d    = rs_q;
      e_d     = e_q;
      data_d  = data_q;

      case (state_q)
         StIdle: begin
            timer_d = '0;
            rs_d    = 1'b0;
         end
         StSetup: begin
            if (setup_end) begin
               state_d = StEhigh;
               timer_d = '0;
               e_d     = 1'b1;
            end
         end
         StEhigh: begin
            if (ehigh_end) begin
               state_d = StHold;
               timer_d = '0;
               e_d     = 1'b0;
            end
         end
         StHold: begin
            state_d = StWait;
            timer_d = '0;
         end
         StWait: begin
            if (wait_end) begin
               state_d = StIdle;
               timer_d = '0;
               rs_d    = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
            rs_d    = 1'b0;
            e_d     = 1'b0;
         end
      endcase

      // RS and data are loaded at SETUP entry and held until the next byte.
      if (take_go) begin
         state_d = StSetup;
         timer_d = '0;
         rs_d    = rs_i;
         data_d  = byte_i;
         e_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         data_q  <= data_d;
      end
   end

   assign lcd_rs_o   = rs_q;
   assign lcd_e_o    = e_q;
   assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_line_writer.sv
// Line sequencer: one set-DDRAM-address command followed by NUM_CHARS data writes to an HD44780.
// Define LCD_NUL_TO_SPACE_EN to transmit NUL characters as spaces (address byte unaffected).
module lcd_line_writer
   import lcd_pkg::*;
#(
   parameter int unsigned NUM_CHARS  = 11,
   parameter int unsigned CHAR_W     = 7,
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned E_HIGH_CYC = 12,
   parameter int unsigned WAIT_CYC   = 2000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic                        row_i,
   input  logic [3:0]                  col_i,
   input  logic [NUM_CHARS*CHAR_W-1:0] dat_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        lcd_rs_o,
   output logic                        lcd_rw_o,
   output logic                        lcd_e_o,
   output logic [7:0]                  lcd_data_o
);

   localparam int unsigned LineW = NUM_CHARS * CHAR_W;
   localparam int unsigned IdxW  = $clog2(NUM_CHARS + 1);

   logic             active_q, active_d;
   logic             done_q, done_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [LineW-1:0] line_q, line_d;

   logic              go, go_rs, byte_ack;
   logic [7:0]        go_byte, data_byte;
   logic [CHAR_W-1:0] char_sel;

   always_comb begin
      char_sel = '0;
      for (int k = 0; k < NUM_CHARS; k++) begin
         if (idx_q == IdxW'(k)) begin
            char_sel = line_q[LineW - CHAR_W * (k + 1) +: CHAR_W];
         end
      end
   end

`ifdef LCD_NUL_TO_SPACE_EN
   assign data_byte = (char_sel == '0) ? LCD_SPACE : 8'(char_sel);
`else
   assign data_byte = 8'(char_sel);
`endif

   // idx_q names the next character to send; reaching NUM_CHARS on an ack ends the line.
   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      line_d   = line_q;
      done_d   = 1'b0;
      go       = 1'b0;
      go_rs    = 1'b0;
      go_byte  = data_byte;

      if (!active_q) begin
         if (start_i) begin
            go       = 1'b1;
            go_rs    = 1'b0;
            go_byte  = ddram_addr(row_i, col_i);
            line_d   = dat_i;
            idx_d    = '0;
            active_d = 1'b1;
         end
      end else if (byte_ack) begin
         if (idx_q == IdxW'(NUM_CHARS)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end else begin
            go      = 1'b1;
            go_rs   = 1'b1;
            go_byte = data_byte;
            idx_d   = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         done_q   <= 1'b0;
         idx_q    <= '0;
         line_q   <= '0;
      end else begin
         active_q <= active_d;
         done_q   <= done_d;
         idx_q    <= idx_d;
         line_q   <= line_d;
      end
   end

   lcd_byte_writer #(
      .SETUP_CYC  (SETUP_CYC),
      .E_HIGH_CYC (E_HIGH_CYC),
      .WAIT_CYC   (WAIT_CYC)
   ) u_byte_writer (
      .clk        (clk),
      .rst        (rst),
      .go_i       (go),
      .rs_i       (go_rs),
      .byte_i     (go_byte),
      .ack_o      (byte_ack),
      .lcd_rs_o   (lcd_rs_o),
      .lcd_e_o    (lcd_e_o),
      .lcd_data_o (lcd_data_o)
   );

   assign busy_o   = active_q;
   assign done_o   = done_q;
   assign lcd_rw_o = 1'b0;

endmodule

// File: doc/lcd_line_writer.md
Name: lcd_line_writer

Overview:
- Sequencer that transfers one 77-bit packed character line (11 × 7-bit ASCII, first character in the MSBs) to an HD44780-compatible character LCD over the 8-bit parallel bus.
- Sits between the quantity/price/total formatting logic and the LCD pins.
- On a start request it issues one set-DDRAM-address command, then 11 data writes, each with programmed E-pulse timing and settle wait.
- Lets the terminal controller time-share a single LCD among several formatted lines.

Parameters:
- NUM_CHARS, 11, characters per line; dat_i width = NUM_CHARS*CHAR_W.
- CHAR_W, 7, bits per character.
- SETUP_CYC, 2, cycles RS/data stable before E rises (min 1).
- E_HIGH_CYC, 12, cycles E held high (min 1).
- WAIT_CYC, 2000, cycles after E falls before the next write (~40 us at 50 MHz; min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request to write one line; sampled only in IDLE
- row_i  in  1  LCD row (0 = base 0x00, 1 = base 0x40)
- col_i  in  4  starting column 0..15
- dat_i  in  77  packed line; char k = dat_i[76-7k -: 7]
- busy_o  out  1  high from the cycle after acceptance until return to IDLE
- done_o  out  1  one-cycle pulse when the line is complete
- lcd_rs_o  out  1  0 = command, 1 = data
- lcd_rw_o  out  1  tied 0 (write only)
- lcd_e_o  out  1  LCD enable strobe
- lcd_data_o  out  8  LCD data bus

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - char index 0;
  - timer 0.
- Reset mid-operation: outputs, including lcd_e_o, go low on the next edge. No partial completion and no done_o.
- Acceptance:
  - In IDLE with start_i=1, latch dat_i, row_i and col_i. Go to SETUP for the address command; busy_o=1 next cycle.
  - start_i is ignored while busy_o=1. There is no queueing.
- Address byte: 0x80 | (row_i ? 0x40 : 0x00) | col_i, sent with RS=0.
- Data bytes: {1'b0, char k} with RS=1, for k = 0..NUM_CHARS-1 in order.
- Per-byte sequence; RS/data are driven at SETUP entry and held constant through HOLD:
  - SETUP: E=0, SETUP_CYC cycles.
  - EHIGH: E=1, E_HIGH_CYC cycles.
  - HOLD: E=0, 1 cycle.
  - WAIT: E=0, WAIT_CYC cycles.
  - Per-byte period T = SETUP_CYC + E_HIGH_CYC + 1 + WAIT_CYC.
- Sequencing: after WAIT, increment the index and return to SETUP. After the WAIT of the last character, go to IDLE.
- Completion:
  - done_o=1 and busy_o=0 in the first IDLE cycle.
  - A start_i in that same cycle is accepted.
  - Start-to-done latency = 1 + (NUM_CHARS+1)*T cycles.
- lcd_rw_o is always 0. lcd_data_o holds its last value in IDLE. lcd_rs_o returns to 0 in IDLE.
- Column wrap: col_i is not range-checked. Characters past column 15 follow the LCD's own DDRAM auto-increment; the block does not intervene.
- dat_i changes after acceptance have no effect.

Optional Feature:
- Macro: LCD_NUL_TO_SPACE_EN.
- Defined: any character equal to 7'h00 is sent as 8'h20 (space), so blank fields clear old glyphs.
- Undefined: characters are sent verbatim; 0x00 selects CGRAM glyph 0.
- The address byte is never affected.

Decomposition:
- Package lcd_pkg:
  - FSM state enum (IDLE, SETUP, EHIGH, HOLD, WAIT);
  - LCD_CMD_SET_DDRAM = 8'h80;
  - LCD_ROW1_BASE = 8'h40;
  - LCD_SPACE = 8'h20;
  - CHAR_W.
- Sub-module lcd_byte_writer:
  - Takes one byte plus RS on a go/ack handshake.
  - Owns the SETUP/EHIGH/HOLD/WAIT timer and the E strobe.
  - lcd_line_writer owns the line FSM, index and latching.

Test Plan:
- Sim parameters: SETUP_CYC=2, E_HIGH_CYC=3, WAIT_CYC=4, giving T=10.
- Basic line: dat_i="TOT:3" + "12.34$", row=1, col=0, start pulse.
  - Bytes: 0xC0 (RS=0), then 0x54,0x4F,0x54,0x3A,0x33,0x31,0x32,0x2E,0x33,0x34,0x24 (RS=1).
  - Each E high exactly 3 cycles; done_o at cycle 121 after start.
- Address: row=0, col=5 -> first byte 0x85, RS=0. Change dat_i after acceptance -> transmitted bytes unchanged.
- Busy/start: start_i held high continuously.
  - Second line begins in the same cycle done_o pulses; no byte is dropped.
  - Extra starts during busy produce no extra E pulses.
- NUL handling: dat_i with chars 0..4 = 7'h00.
  - With LCD_NUL_TO_SPACE_EN: five 0x20 bytes.
  - Without: five 0x00 bytes.
  - Address byte identical in both builds.
- Reset mid-line: assert rst during EHIGH of char 6.
  - Next cycle: lcd_e_o=0, busy_o=0, all outputs 0, no done_o.
  - A new start after reset sends the address first.
- Timing invariants: assertions that RS/data are stable whenever lcd_e_o=1 and for 1 cycle after its fall, and that every E-rise spacing equals T.
